conv_stream_engine: RTL

- Parametrised successor to the parallel convolution kernel block: one output feature-map pixel per window pass, computed with a single time-multiplexed MAC over channels × kernel rows × kernel columns.
- Adds zero padding, any stride, configurable accumulator width, enable stalling, and a streaming per-pixel output handshake.
- Sits between the feature-map/weight buffers and the pooling/activation stage of the CNN datapath.

---
 rtl/conv_stream_engine.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/conv_stream_engine.sv
// rtl/conv_stream_engine.sv - time-multiplexed conv MAC engine with streaming per-pixel output
// Define CONV_STREAM_RELU_EN to clamp negative results to zero at emit time.
module conv_stream_engine #(
  parameter int BIT_SIZE      = 9,
  parameter int INPUT_WIDTH   = 4,
  parameter int INPUT_HEIGHT  = 4,
  parameter int CHANNEL_SIZE  = 2,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int STRIDE        = 1,
  parameter int PADDING       = 0,
  parameter int ACC_BIT       = 24,
  parameter int OUTPUT_WIDTH  = (INPUT_WIDTH + 2*PADDING - KERNEL_WIDTH) / STRIDE + 1,
  parameter int OUTPUT_HEIGHT = (INPUT_HEIGHT + 2*PADDING - KERNEL_HEIGHT) / STRIDE + 1
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic                                                   enable,
  input  logic                                                   start,
  input  logic [INPUT_WIDTH*INPUT_HEIGHT*CHANNEL_SIZE*BIT_SIZE-1:0] input_buffer,
  input  logic [KERNEL_WIDTH*KERNEL_HEIGHT*CHANNEL_SIZE*BIT_SIZE-1:0] kernel_buffer,
  input  logic [BIT_SIZE-1:0]                                    bias,
  output logic [ACC_BIT-1:0]                                     out_data,
  output logic [15:0]                                            out_x,
  output logic [15:0]                                            out_y,
  output logic                                                   out_valid,
  output logic                                                   busy,
  output logic                                                   done
);

  localparam int IN_BITS = INPUT_WIDTH*INPUT_HEIGHT*CHANNEL_SIZE*BIT_SIZE;
  localparam int K_BITS  = KERNEL_WIDTH*KERNEL_HEIGHT*CHANNEL_SIZE*BIT_SIZE;
  localparam int IN_AW   = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam int K_AW    = (K_BITS > 1) ? $clog2(K_BITS) : 1;

  localparam logic [15:0] KX_LAST = 16'(KERNEL_WIDTH - 1);
  localparam logic [15:0] KY_LAST = 16'(KERNEL_HEIGHT - 1);
  localparam logic [15:0] CH_LAST = 16'(CHANNEL_SIZE - 1);
  localparam logic [15:0] OX_LAST = 16'(OUTPUT_WIDTH - 1);
  localparam logic [15:0] OY_LAST = 16'(OUTPUT_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;
  state_t state, state_next;

  logic [15:0] kx, ky, ch, ox, oy;
  logic signed [ACC_BIT-1:0] acc;

  int ix, iy, pix_idx, w_idx;
  logic in_map;
  logic [IN_AW-1:0] pix_base;
  logic [K_AW-1:0]  w_base;
  logic signed [BIT_SIZE-1:0]   px, w;
  logic signed [2*BIT_SIZE-1:0] prod;
  logic signed [ACC_BIT-1:0]    prod_ext, bias_ext, sum, result;
  logic last_term, last_pixel;

  // Map the current (ox,oy,kx,ky,ch) to flat buffer offsets; padded taps read as zero.
  always_comb begin
    ix       = int'(ox) * STRIDE + int'(kx) - PADDING;
    iy       = int'(oy) * STRIDE + int'(ky) - PADDING;
    in_map   = (ix >= 0) && (ix < INPUT_WIDTH) && (iy >= 0) && (iy < INPUT_HEIGHT);
    pix_idx  = in_map ? ((int'(ch) * INPUT_HEIGHT + iy) * INPUT_WIDTH + ix) : 0;
    w_idx    = (int'(ch) * KERNEL_HEIGHT + int'(ky)) * KERNEL_WIDTH + int'(kx);
    pix_base = IN_AW'(pix_idx * BIT_SIZE);
    w_base   = K_AW'(w_idx * BIT_SIZE);
    px       = in_map ? input_buffer[pix_base +: BIT_SIZE] : '0;
    w        = kernel_buffer[w_base +: BIT_SIZE];
  end

  assign prod       = (2*BIT_SIZE)'(px) * (2*BIT_SIZE)'(w);
  assign prod_ext   = ACC_BIT'(prod);
  assign bias_ext   = ACC_BIT'($signed(bias));
  assign sum        = acc + bias_ext;
  assign last_term  = (kx == KX_LAST) && (ky == KY_LAST) && (ch == CH_LAST);
  assign last_pixel = (ox == OX_LAST) && (oy == OY_LAST);

`ifdef CONV_STREAM_RELU_EN
  assign result = sum[ACC_BIT-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (enable) begin
      case (state)
        IDLE:    if (start) state_next = MAC;
        MAC:     if (last_term) state_next = EMIT;
        EMIT:    state_next = last_pixel ? IDLE : MAC;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      kx        <= '0;
      ky        <= '0;
      ch        <= '0;
      ox        <= '0;
      oy        <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (enable) begin
        case (state)
          IDLE: begin
            if (start) begin
              kx   <= '0;
              ky   <= '0;
              ch   <= '0;
              ox   <= '0;
              oy   <= '0;
              acc  <= '0;
              busy <= 1'b1;
            end
          end
          MAC: begin
            acc <= acc + prod_ext;
            if (kx == KX_LAST) begin
              kx <= '0;
              if (ky == KY_LAST) begin
                ky <= '0;
                ch <= (ch == CH_LAST) ? '0 : ch + 16'd1;
              end else begin
                ky <= ky + 16'd1;
              end
            end else begin
              kx <= kx + 16'd1;
            end
          end
          EMIT: begin
            out_data  <= result;
            out_x     <= ox;
            out_y     <= oy;
            out_valid <= 1'b1;
            acc       <= '0;
            if (last_pixel) begin
              ox   <= '0;
              oy   <= '0;
              done <= 1'b1;
              busy <= 1'b0;
            end else if (ox == OX_LAST) begin
              ox <= '0;
              oy <= oy + 16'd1;
            end else begin
              ox <= ox + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
